// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package pipeline_ctrl_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {RUN, REDIR_PEND, DISCARD} hz_state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and stall/flush controls back to them.
interface hazard_ctrl_if #(
  parameter int XLEN  = pipeline_ctrl_pkg::XLEN,
  parameter int REG_W = pipeline_ctrl_pkg::REG_W,
  parameter int CNT_W = pipeline_ctrl_pkg::CNT_W
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic             imem_busy;
  logic             imem_valid;
  logic             dmem_busy;

  logic             pc_en;
  logic             pc_sel_redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, ex_target, imem_busy, imem_valid, dmem_busy,
    input  pc_en, pc_sel_redirect, redirect_pc, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_redirect, ex_target, imem_busy, imem_valid, dmem_busy,
    output pc_en, pc_sel_redirect, redirect_pc, if_id_stall, if_id_flush,
           id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_load_use.sv
// Combinational load-use detector: ID reads a register that the load in EX will write.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = pipeline_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);
  // x0 is never written, so a load targeting it cannot create a hazard
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: prioritises memory freeze, redirects, load-use and fetch stalls,
// holds redirects that arrive during a freeze and drops the wrong-path fetch beat.
module hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int XLEN  = pipeline_ctrl_pkg::XLEN,
  parameter int REG_W = pipeline_ctrl_pkg::REG_W,
  parameter int CNT_W = pipeline_ctrl_pkg::CNT_W
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  hz_state_t        state, state_nxt;
  logic [XLEN-1:0]  tgt_q, tgt_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .rs1        (hz.id_rs1),
    .rs2        (hz.id_rs2),
    .use_rs1    (hz.id_use_rs1),
    .use_rs2    (hz.id_use_rs2),
    .ex_rd      (hz.ex_rd),
    .ex_mem_read(hz.ex_mem_read),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      tgt_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      tgt_q <= tgt_nxt;
      if (!hz.pc_en && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = cnt_q;

  always_comb begin
    state_nxt          = state;
    tgt_nxt            = tgt_q;
    hz.pc_en           = 1'b0;
    hz.pc_sel_redirect = 1'b0;
    hz.redirect_pc     = '0;
    hz.if_id_stall     = 1'b0;
    hz.if_id_flush     = 1'b0;
    hz.id_ex_stall     = 1'b0;
    hz.id_ex_flush     = 1'b0;
    hz.ex_mem_stall    = 1'b0;
    hz.mem_wb_flush    = 1'b0;

    if (rst) begin
      hz.if_id_flush = 1'b1;
      hz.id_ex_flush = 1'b1;
    end else if (hz.dmem_busy) begin
      // Freeze is identical in every state; only RUN can capture a new redirect
      hz.if_id_stall  = 1'b1;
      hz.id_ex_stall  = 1'b1;
      hz.ex_mem_stall = 1'b1;
      hz.mem_wb_flush = 1'b1;
      if ((state == RUN) && hz.ex_redirect) begin
        tgt_nxt   = hz.ex_target;
        state_nxt = REDIR_PEND;
      end
    end else begin
      case (state)
        RUN: begin
          if (hz.ex_redirect) begin
            hz.pc_en           = 1'b1;
            hz.pc_sel_redirect = 1'b1;
            hz.redirect_pc     = hz.ex_target;
            hz.if_id_flush     = 1'b1;
            hz.id_ex_flush     = 1'b1;
            state_nxt          = hz.imem_busy ? DISCARD : RUN;
          end else if (load_use) begin
            hz.if_id_stall = 1'b1;
            hz.id_ex_flush = 1'b1;
          end else if (!hz.imem_valid) begin
            hz.if_id_flush = 1'b1;
          end else begin
            hz.pc_en = 1'b1;
          end
        end
        REDIR_PEND: begin
          hz.pc_en           = 1'b1;
          hz.pc_sel_redirect = 1'b1;
          hz.redirect_pc     = tgt_q;
          hz.if_id_flush     = 1'b1;
          hz.id_ex_flush     = 1'b1;
          state_nxt          = hz.imem_busy ? DISCARD : RUN;
        end
        DISCARD: begin
          // The beat returning now belongs to the old path and is dropped
          hz.if_id_flush = 1'b1;
          if (hz.imem_valid)
            state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; control outputs are compared as one packed vector.
module tb_hazard_ctrl;
  localparam int CW = 4;

  // ctrl bit order: pc_en, pc_sel_redirect, if_id_stall, if_id_flush,
  //                 id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
  localparam logic [7:0] C_RUN    = 8'h80;
  localparam logic [7:0] C_RESET  = 8'h14;
  localparam logic [7:0] C_FREEZE = 8'h2B;
  localparam logic [7:0] C_REDIR  = 8'hD4;
  localparam logic [7:0] C_LDUSE  = 8'h24;
  localparam logic [7:0] C_FLUSH  = 8'h10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if #(.XLEN(32), .REG_W(5), .CNT_W(CW)) bus ();

  hazard_ctrl #(.XLEN(32), .REG_W(5), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] ctrl;
  assign ctrl = {bus.pc_en, bus.pc_sel_redirect, bus.if_id_stall, bus.if_id_flush,
                 bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush};

  task automatic idle_inputs;
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = '0;
    bus.ex_mem_read = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.ex_target   = '0;
    bus.imem_busy   = 1'b0;
    bus.imem_valid  = 1'b1;
    bus.dmem_busy   = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    @(negedge clk);
    checks++;
    if (ctrl !== C_RESET) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl, C_RESET); end
    checks++;
    if (bus.stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", bus.stall_cnt); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL run_idle: got %b expected %b", ctrl, C_RUN); end
    tick();
  endtask

  task automatic test_load_use;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_LDUSE) begin errors++; $display("[TB] FAIL load_use_rs1: got %b expected %b", ctrl, C_LDUSE); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL load_use_clear: got %b expected %b", ctrl, C_RUN); end
    tick();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_LDUSE) begin errors++; $display("[TB] FAIL load_use_rs2: got %b expected %b", ctrl, C_LDUSE); end
    tick();
    idle_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL load_use_x0: got %b expected %b", ctrl, C_RUN); end
    tick();
    bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL load_use_unused: got %b expected %b", ctrl, C_RUN); end
    tick();
    idle_inputs();
  endtask

  task automatic test_redirect;
    bus.ex_redirect = 1'b1; bus.ex_target = 32'h100; bus.imem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_REDIR) begin errors++; $display("[TB] FAIL redirect_ctrl: got %b expected %b", ctrl, C_REDIR); end
    checks++;
    if (bus.redirect_pc !== 32'h100) begin errors++; $display("[TB] FAIL redirect_pc: got %h expected 100", bus.redirect_pc); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL redirect_stay_run: got %b expected %b", ctrl, C_RUN); end
    tick();
  endtask

  task automatic test_redirect_in_freeze;
    bus.dmem_busy = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== C_FREEZE) begin errors++; $display("[TB] FAIL freeze_cycle%0d: got %b expected %b", i, ctrl, C_FREEZE); end
      tick();
      bus.ex_redirect = 1'b0;
      bus.ex_target   = 32'hDEAD;
    end
    bus.dmem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_REDIR) begin errors++; $display("[TB] FAIL pend_release_ctrl: got %b expected %b", ctrl, C_REDIR); end
    checks++;
    if (bus.redirect_pc !== 32'h200) begin errors++; $display("[TB] FAIL pend_release_pc: got %h expected 200", bus.redirect_pc); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL pend_after: got %b expected %b", ctrl, C_RUN); end
    tick();
  endtask

  task automatic test_discard;
    bus.ex_redirect = 1'b1; bus.ex_target = 32'h300; bus.imem_busy = 1'b1; bus.imem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_REDIR) begin errors++; $display("[TB] FAIL discard_redirect: got %b expected %b", ctrl, C_REDIR); end
    tick();
    bus.ex_redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("[TB] FAIL discard_wait: got %b expected %b", ctrl, C_FLUSH); end
    tick();
    bus.imem_valid = 1'b1; bus.imem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("[TB] FAIL discard_drop_beat: got %b expected %b", ctrl, C_FLUSH); end
    tick();
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL discard_resume: got %b expected %b", ctrl, C_RUN); end
    tick();
    idle_inputs();
  endtask

  task automatic test_priority;
    bus.dmem_busy = 1'b1; bus.imem_valid = 1'b0;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_FREEZE) begin errors++; $display("[TB] FAIL prio_freeze: got %b expected %b", ctrl, C_FREEZE); end
    tick();
    bus.dmem_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_LDUSE) begin errors++; $display("[TB] FAIL prio_loaduse_over_fetch: got %b expected %b", ctrl, C_LDUSE); end
    tick();
    bus.ex_mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_FLUSH) begin errors++; $display("[TB] FAIL prio_fetch_wait: got %b expected %b", ctrl, C_FLUSH); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_in_pend;
    bus.dmem_busy = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 32'h400;
    @(negedge clk);
    checks++;
    if (ctrl !== C_FREEZE) begin errors++; $display("[TB] FAIL rstpend_freeze: got %b expected %b", ctrl, C_FREEZE); end
    tick();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== C_RESET) begin errors++; $display("[TB] FAIL rstpend_reset: got %b expected %b", ctrl, C_RESET); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL rstpend_no_redirect: got %b expected %b", ctrl, C_RUN); end
    checks++;
    if (bus.stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rstpend_cnt: got %0d expected 0", bus.stall_cnt); end
    tick();
    bus.imem_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        @(negedge clk);
        checks++;
        if (bus.stall_cnt !== 4'd3) begin errors++; $display("[TB] FAIL cnt_count: got %0d expected 3", bus.stall_cnt); end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL cnt_saturate: got %0d expected 15", bus.stall_cnt); end
    tick();
    bus.imem_valid = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (bus.stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL cnt_hold: got %0d expected 15", bus.stall_cnt); end
    checks++;
    if (ctrl !== C_RUN) begin errors++; $display("[TB] FAIL cnt_run: got %b expected %b", ctrl, C_RUN); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_in_freeze();
    test_discard();
    test_priority();
    test_reset_in_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
